boot_loader: RTL and testbench
==============================

// Module: boot_loader
// PURPOSE
//  Upstream feeder of the fault-tolerant SoC: receives a program image as a byte stream,
//  assembles little-endian 32-bit words and writes them into instruction memory over a
//  req/gnt write port. Once the image is loaded (and verified), it raises fetch_enable_o so
//  the cores start fetching from BASE_ADDR. This replaces the backdoor memory preload.
// PARAMETERS
//  ADDR_WIDTH  32       width of instruction memory byte address
//  BASE_ADDR   32'h0    byte address of the first image word
//  MEM_WORDS   256      instruction memory capacity in words; larger images are rejected
// PORTS
//  clk_i            in   1           clock, all logic on rising edge
//  rst_i            in   1           synchronous reset, active-high
//  rx_valid_i       in   1           byte stream valid
//  rx_data_i        in   8           byte stream data
//  rx_ready_o       out  1           byte accepted when rx_valid_i && rx_ready_o
//  mem_req_o        out  1           instruction memory write request
//  mem_gnt_i        in   1           write accepted on mem_req_o && mem_gnt_i
//  mem_addr_o       out  ADDR_WIDTH  byte address, word aligned
//  mem_wdata_o      out  32          write data
//  mem_we_o         out  1           write enable (1 whenever mem_req_o=1)
//  fetch_enable_o   out  1           core fetch enable, sticky until reset
//  boot_done_o      out  1           image loaded and accepted, sticky
//  boot_err_o       out  1           image rejected, sticky
//  words_loaded_o   out  16          count of words granted by memory
// BEHAVIOUR
//  Reset: all outputs 0; state LEN_LO; byte and word counters 0. Reset mid-load aborts
//  immediately; memory contents already written are not cleared.
//  Image format: len_lo, len_hi (16-bit word count N, LE), N*4 payload bytes (LE per word),
//  then checksum byte (only with BOOT_CHECKSUM_EN).
//  States: LEN_LO -> LEN_HI -> (N==0 ? CSUM/RUN : N>MEM_WORDS ? ERROR : DATA);
//   DATA collects 4 bytes, then WRITE; WRITE holds req/addr/wdata stable until gnt;
//   on gnt: words_loaded++, next word or, after word N, CSUM (or RUN).
//   CSUM: compare received byte to running XOR of all payload bytes; match -> RUN, else ERROR.
//   RUN: fetch_enable_o=1, boot_done_o=1, rx_ready_o=0; terminal until reset.
//   ERROR: boot_err_o=1, fetch_enable_o=0, rx_ready_o=0; terminal until reset.
//  rx_ready_o=1 only in LEN_LO, LEN_HI, DATA, CSUM. One byte per cycle max; no combinational
//  path rx_valid_i -> rx_ready_o.
//  mem_addr_o = BASE_ADDR + 4*words_loaded_o; word i written at BASE_ADDR+4i, in order.
//  mem_req_o asserted the cycle after the 4th byte is accepted; gnt may come same cycle
//  (1 word per 5 cycles minimum) or be stalled indefinitely; req never drops without gnt.
//  Byte order: first byte of a word -> bits [7:0].
// CONFIGURATION
//  BOOT_CHECKSUM_EN defined: CSUM state present; trailing XOR byte required and checked.
//  Not defined: no checksum byte; last grant goes directly to RUN; boot_err_o only from
//  N>MEM_WORDS.
// STRUCTURE
//  boot_loader_pkg: state enum boot_state_e {LEN_LO,LEN_HI,DATA,WRITE,CSUM,RUN,ERROR},
//  BYTES_PER_WORD=4 constant.
//  Sub-module boot_word_assembler: byte shift-in, 2-bit byte index, word_valid pulse; FSM,
//  counters and memory handshake stay in boot_loader.
// TESTING
//  4-word image 0x00000013 x3, 0x0000006F, gnt tied 1 -> writes at 0x0,0x4,0x8,0xC; done=1,
//   fetch_enable=1, words_loaded=4.
//  Same image, gnt low 7 cycles per write -> req/addr/wdata stable, rx_ready=0 while waiting,
//   same final result.
//  [BOOT_CHECKSUM_EN] 2-word image, checksum off by 1 -> boot_err=1, fetch_enable=0,
//   words_loaded=2.
//  Length 0 (+csum 0x00) -> no mem_req, done=1 within 3 cycles of last byte.
//  Length 257 with MEM_WORDS=256 -> ERROR after len_hi, no mem_req, rx_ready=0.
//  rst_i pulsed after 6 of 16 payload bytes -> outputs 0, state LEN_LO; full reload succeeds.

Source files
------------

// File: rtl/boot_loader_pkg.sv
// Shared types for the byte-stream boot loader.
package boot_loader_pkg;

  typedef enum logic [2:0] {
    LEN_LO,
    LEN_HI,
    DATA,
    WRITE,
    CSUM,
    RUN,
    ERROR
  } boot_state_e;

  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/boot_word_assembler.sv
// Shifts accepted bytes into a little-endian 32-bit word.
module boot_word_assembler
  import boot_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  logic [1:0]  idx_q, idx_d;
  logic [31:0] word_q, word_d;

  localparam logic [1:0] LastIdx = 2'(BYTES_PER_WORD - 1);

  always_comb begin
    idx_d  = idx_q;
    word_d = word_q;
    if (byte_valid_i) begin
      idx_d  = idx_q + 2'd1;
      // newest byte enters at the top so the first lands in [7:0]
      word_d = {byte_i, word_q[31:8]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q  <= '0;
      word_q <= '0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end

  assign word_o       = word_q;
  assign word_valid_o = byte_valid_i && (idx_q == LastIdx);

endmodule

// File: rtl/boot_loader.sv
// Byte-stream image loader into instruction memory.
// Optional trailing XOR checksum: define BOOT_CHECKSUM_EN.
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    MEM_WORDS  = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  rx_valid_i,
  input  logic [7:0]            rx_data_i,
  output logic                  rx_ready_o,
  output logic                  mem_req_o,
  input  logic                  mem_gnt_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  output logic                  mem_we_o,
  output logic                  fetch_enable_o,
  output logic                  boot_done_o,
  output logic                  boot_err_o,
  output logic [15:0]           words_loaded_o
);

`ifdef BOOT_CHECKSUM_EN
  localparam boot_state_e TailSt = CSUM;
  logic [7:0] csum_q, csum_d;
`else
  localparam boot_state_e TailSt = RUN;
`endif

  boot_state_e state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] len_rx;
  logic        rx_fire;
  logic        word_valid;
  logic [31:0] word;

  assign rx_ready_o = !rst_i && (state_q == LEN_LO || state_q == LEN_HI ||
                                 state_q == DATA   || state_q == CSUM);
  assign rx_fire    = rx_valid_i && rx_ready_o;
  assign len_rx     = {rx_data_i, len_q[7:0]};

  boot_word_assembler u_asm (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .byte_valid_i (rx_fire && state_q == DATA),
    .byte_i       (rx_data_i),
    .word_o       (word),
    .word_valid_o (word_valid)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
`ifdef BOOT_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      LEN_LO: if (rx_fire) begin
        len_d[7:0] = rx_data_i;
        state_d    = LEN_HI;
      end
      LEN_HI: if (rx_fire) begin
        len_d[15:8] = rx_data_i;
        if (len_rx == 16'd0)
          state_d = TailSt;
        else if ({16'd0, len_rx} > 32'(MEM_WORDS))
          state_d = ERROR;
        else
          state_d = DATA;
      end
      DATA: begin
`ifdef BOOT_CHECKSUM_EN
        if (rx_fire) csum_d = csum_q ^ rx_data_i;
`endif
        if (word_valid) state_d = WRITE;
      end
      WRITE: if (mem_gnt_i) begin
        cnt_d   = cnt_q + 16'd1;
        state_d = (cnt_d == len_q) ? TailSt : DATA;
      end
`ifdef BOOT_CHECKSUM_EN
      CSUM: if (rx_fire)
        state_d = (rx_data_i == csum_q) ? RUN : ERROR;
`endif
      RUN, ERROR: ;
      default: state_d = ERROR;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= LEN_LO;
      len_q   <= '0;
      cnt_q   <= '0;
`ifdef BOOT_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
`ifdef BOOT_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign mem_req_o      = (state_q == WRITE);
  assign mem_we_o       = mem_req_o;
  assign mem_wdata_o    = word;
  assign mem_addr_o     = BASE_ADDR + ADDR_WIDTH'({cnt_q, 2'b00});
  assign fetch_enable_o = (state_q == RUN);
  assign boot_done_o    = (state_q == RUN);
  assign boot_err_o     = (state_q == ERROR);
  assign words_loaded_o = cnt_q;

endmodule

// File: tb/tb_boot_loader.sv
// Directed self-checking bench for boot_loader.
module tb_boot_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_ready_o;
  logic        mem_req_o;
  logic        mem_gnt = 1'b0;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_we_o;
  logic        fetch_enable_o;
  logic        boot_done_o;
  logic        boot_err_o;
  logic [15:0] words_loaded_o;

  int checks = 0;
  int errors = 0;
  int stall_cfg = 0;
  int wcnt = 0;
  bit req_seen = 0;
  logic [31:0] h_a, h_d;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [31:0] img[4] = '{32'h13, 32'h13, 32'h13, 32'h6F};

  always #5 clk = ~clk;

  boot_loader dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .rx_valid_i     (rx_valid),
    .rx_data_i      (rx_data),
    .rx_ready_o     (rx_ready_o),
    .mem_req_o      (mem_req_o),
    .mem_gnt_i      (mem_gnt),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_we_o       (mem_we_o),
    .fetch_enable_o (fetch_enable_o),
    .boot_done_o    (boot_done_o),
    .boot_err_o     (boot_err_o),
    .words_loaded_o (words_loaded_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory responder: grants after stall_cfg stalled cycles
  always @(negedge clk) begin
    if (mem_req_o) begin
      req_seen = 1;
      if (wcnt == stall_cfg) begin
        mem_gnt = 1'b1;
        chk("mem_we", {31'd0, mem_we_o}, 32'd1);
        wr_addr.push_back(mem_addr_o);
        wr_data.push_back(mem_wdata_o);
        wcnt = 0;
      end else begin
        mem_gnt = 1'b0;
        if (wcnt == 0) begin
          h_a = mem_addr_o;
          h_d = mem_wdata_o;
        end else begin
          chk("stall_addr", mem_addr_o, h_a);
          chk("stall_wdata", mem_wdata_o, h_d);
        end
        chk("stall_rx_ready", {31'd0, rx_ready_o}, 32'd0);
        wcnt++;
      end
    end else begin
      mem_gnt = 1'b0;
      wcnt = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready_o && n < 60) begin
      tick();
      n++;
    end
    if (!rx_ready_o) chk("rx_ready_timeout", {31'd0, rx_ready_o}, 32'd1);
    else tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx_valid = 1'b0;
    tick();
    chk("rst_rx_ready", {31'd0, rx_ready_o}, 32'd0);
    chk("rst_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_done", {31'd0, boot_done_o}, 32'd0);
    chk("rst_err", {31'd0, boot_err_o}, 32'd0);
    chk("rst_fetch", {31'd0, fetch_enable_o}, 32'd0);
    chk("rst_words", {16'd0, words_loaded_o}, 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_rx_ready", {31'd0, rx_ready_o}, 32'd1);
    wr_addr.delete();
    wr_data.delete();
    req_seen = 0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!boot_done_o && !boot_err_o && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic load_img4();
    send_byte(8'd4);
    send_byte(8'd0);
    for (int i = 0; i < 4; i++) send_word(img[i]);
`ifdef BOOT_CHECKSUM_EN
    send_byte(8'h7C);
`endif
    wait_done();
  endtask

  task automatic check_img4(input string tag);
    chk({tag, "_nwrites"}, 32'(wr_addr.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < wr_addr.size()) begin
        chk({tag, "_addr"}, wr_addr[i], 32'(4 * i));
        chk({tag, "_data"}, wr_data[i], img[i]);
      end
    end
    chk({tag, "_done"}, {31'd0, boot_done_o}, 32'd1);
    chk({tag, "_fetch"}, {31'd0, fetch_enable_o}, 32'd1);
    chk({tag, "_err"}, {31'd0, boot_err_o}, 32'd0);
    chk({tag, "_words"}, {16'd0, words_loaded_o}, 32'd4);
    chk({tag, "_rx_ready"}, {31'd0, rx_ready_o}, 32'd0);
  endtask

  initial begin
    // 4-word image, grant same cycle
    stall_cfg = 0;
    do_reset();
    load_img4();
    check_img4("img_gnt1");

    // Same image, 7 stalled cycles per write
    stall_cfg = 7;
    do_reset();
    load_img4();
    check_img4("img_stall");
    stall_cfg = 0;

`ifdef BOOT_CHECKSUM_EN
    do_reset();
    send_byte(8'd2);
    send_byte(8'd0);
    send_word(32'h11223344);
    send_word(32'h55667788);
    send_byte(8'h89);
    wait_done();
    chk("csum_err", {31'd0, boot_err_o}, 32'd1);
    chk("csum_fetch", {31'd0, fetch_enable_o}, 32'd0);
    chk("csum_words", {16'd0, words_loaded_o}, 32'd2);
`endif

    // Zero-length image
    do_reset();
    send_byte(8'd0);
    send_byte(8'd0);
`ifdef BOOT_CHECKSUM_EN
    send_byte(8'h00);
`endif
    for (int i = 0; i < 3; i++) if (!boot_done_o) tick();
    chk("len0_done", {31'd0, boot_done_o}, 32'd1);
    chk("len0_fetch", {31'd0, fetch_enable_o}, 32'd1);
    chk("len0_req_seen", {31'd0, req_seen}, 32'd0);

    // Oversized image: 257 words
    do_reset();
    send_byte(8'h01);
    send_byte(8'h01);
    tick();
    chk("big_err", {31'd0, boot_err_o}, 32'd1);
    chk("big_rx_ready", {31'd0, rx_ready_o}, 32'd0);
    chk("big_fetch", {31'd0, fetch_enable_o}, 32'd0);
    chk("big_done", {31'd0, boot_done_o}, 32'd0);
    chk("big_req_seen", {31'd0, req_seen}, 32'd0);

    // Reset after 6 payload bytes, then full reload
    do_reset();
    send_byte(8'd4);
    send_byte(8'd0);
    send_word(img[0]);
    send_byte(8'h13);
    send_byte(8'h00);
    chk("abort_words", {16'd0, words_loaded_o}, 32'd1);
    do_reset();
    load_img4();
    check_img4("reload");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
